// File: rtl/mux_nt1_rr.sv
// mux_nt1_rr: N-to-1 registered stream mux with fixed-select or round-robin arbitration.
module mux_nt1_rr #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);
  logic [W-1:0]   out_data_q, out_data_d, gnt_data;
  logic [SW-1:0]  out_ch_q, out_ch_d, ptr_q, ptr_d, gnt;
  logic           out_valid_q, out_valid_d, gnt_vld, load_ok, xfer;
  logic [2*N-1:0] rot;
  logic [SW:0]    sum;
  always_comb begin
    gnt_vld = 1'b0;
    sum = '0;
    rot = {in_valid, in_valid} >> ptr_q;
    // descending scan so the nearest valid channel after ptr wins
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) begin
        sum = {1'b0, ptr_q} + (SW + 1)'(k);
        gnt_vld = mode;
      end
    gnt = (sum >= (SW + 1)'(N)) ? SW'(sum - (SW + 1)'(N)) : SW'(sum);
    for (int i = 0; i < N; i++)
      if (!mode && sel == SW'(i) && in_valid[i]) begin
        gnt = SW'(i);
        gnt_vld = 1'b1;
      end
    gnt_data = '0;
    for (int i = 0; i < N; i++)
      if (gnt == SW'(i)) gnt_data = in_data[i*W +: W];
    load_ok = !out_valid_q || out_ready;
    xfer = gnt_vld && load_ok && !rst;
    for (int i = 0; i < N; i++) in_ready[i] = xfer && gnt == SW'(i);
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d = xfer ? gnt_data : out_data_q;
    out_ch_d = xfer ? gnt : out_ch_q;
    ptr_d = (xfer && mode) ? ((gnt == SW'(N - 1)) ? '0 : gnt + SW'(1)) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_nt1_rr.sv
// tb_mux_nt1_rr: table-driven directed check of mux_nt1_rr at W=8, N=4.
module tb_mux_nt1_rr;
  logic        clk = 0, rst, mode, out_valid, out_ready;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  sel, out_ch;
  logic [7:0]  out_data;
  int checks = 0, failures = 0;

  mux_nt1_rr #(.W(8), .N(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] e_ir;
    logic       e_ov;
    logic [1:0] e_ch;
    logic [7:0] e_d;
  } vec_t;

  vec_t v [35];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // reset
    v[0]  = '{1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    v[1]  = '{1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    // fixed select 0,1,3,2
    v[2]  = '{1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    v[3]  = '{1'b0, 1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    v[4]  = '{1'b0, 1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    v[5]  = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    // round-robin fairness
    for (int i = 0; i < 8; i++)
      v[6+i] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (i % 4)), 1'b1, 2'(i % 4), 8'(8'h11 * (i % 4 + 1))};
    // sparse round-robin 1010
    v[14] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    v[15] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    v[16] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    v[17] = '{1'b0, 1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h22};
    // mode switch with ptr=2 retained
    v[18] = '{1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    v[19] = '{1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    v[20] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    // backpressure 5 cycles, then no-gap reload from ptr=3
    for (int i = 0; i < 5; i++)
      v[21+i] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h33};
    v[26] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    v[27] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    v[28] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    v[29] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    // reset mid-stream with ptr=3 and a held beat
    v[30] = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    v[31] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    // mode 0 with selected channel invalid, then valid
    v[32] = '{1'b0, 1'b0, 2'd1, 4'hD, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h11};
    v[33] = '{1'b0, 1'b0, 2'd2, 4'hD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    // ptr=1 search wraps to channel 0
    v[34] = '{1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};

    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1; mode = 0; sel = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      rst = v[i].rst; mode = v[i].mode; sel = v[i].sel;
      in_valid = v[i].iv; out_ready = v[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v[i].e_ir));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v[i].e_ov));
      chk($sformatf("v%0d out_ch", i), 32'(out_ch), 32'(v[i].e_ch));
      chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(v[i].e_d));
    end

    // latency: idle, then one beat on ch2 must appear exactly one edge later
    @(negedge clk);
    mode = 1; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("idle out_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0100;
    @(posedge clk); #1;
    in_valid = 0;
    begin
      int n = 1;
      while (!out_valid && n < 5) begin
        @(posedge clk); #1;
        n++;
      end
      chk("latency cycles", 32'(n), 32'd1);
      chk("latency out_ch", 32'(out_ch), 32'd2);
      chk("latency out_data", 32'(out_data), 32'h33);
    end
    @(posedge clk); #1;
    chk("drain out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
